// File: rtl/blur_window_ctrl.sv
// Sequencer for the 4x4 box-blur datapath: qualifies video beats, drives the shift enable,
// tracks pixel coordinates and flags malformed frames, one cycle ahead of the output mux.
module blur_window_ctrl #(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int TAPS    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sop,
    input  logic        eop,
    input  logic        in_valid,
    input  logic        packet_video,
    input  logic        blur_enable,
    output logic        shift_en,
    output logic        out_valid,
    output logic        use_blur,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        frame_done,
    output logic        err_short,
    output logic        err_long
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

    localparam logic [10:0] XMAX = 11'(IMAGE_W - 1);
    localparam logic [9:0]  YMAX = 10'(IMAGE_H - 1);
    localparam logic [10:0] XTAP = 11'(TAPS - 1);
    localparam logic [9:0]  YTAP = 10'(TAPS - 1);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d, x_out_q, x_out_d, cur_x;
    logic [9:0]  y_q, y_d, y_out_q, y_out_d, cur_y;
    logic        blur_en_q, blur_en_d, long_seen_q, long_seen_d;
    logic        out_valid_q, out_valid_d, use_blur_q, use_blur_d;
    logic        frame_done_q, frame_done_d, err_short_q, err_short_d, err_long_q, err_long_d;
    logic        beat, accept, restart, cur_blur, last_pix;

    always_comb begin
        beat     = in_valid & packet_video;
        accept   = beat & ((state_q == ACTIVE) | sop);
        restart  = accept & sop;
        cur_x    = restart ? 11'd0 : x_q;
        cur_y    = restart ? 10'd0 : y_q;
        cur_blur = restart ? blur_enable : blur_en_q;
        last_pix = (cur_x == XMAX) && (cur_y == YMAX);

        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        blur_en_d    = blur_en_q;
        long_seen_d  = long_seen_q;
        out_valid_d  = accept;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        use_blur_d   = 1'b0;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;

        if (accept) begin
            blur_en_d   = cur_blur;
            x_out_d     = cur_x;
            y_out_d     = cur_y;
            use_blur_d  = cur_blur & (cur_x >= XTAP) & (cur_y >= YTAP);
            err_short_d = sop & (state_q == ACTIVE);
            if (last_pix) begin
                x_d = '0;
                y_d = '0;
                if (eop) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    long_seen_d = 1'b0;
                    state_d     = DISCARD;
                end
            end else if (eop) begin
                err_short_d = 1'b1;
                x_d         = '0;
                y_d         = '0;
                state_d     = IDLE;
            end else begin
                state_d = ACTIVE;
                if (cur_x == XMAX) begin
                    x_d = '0;
                    y_d = cur_y + 10'd1;
                end else begin
                    x_d = cur_x + 11'd1;
                    y_d = cur_y;
                end
            end
        end else if (beat && (state_q == DISCARD)) begin
            // Only the first overrun beat of a frame reports err_long.
            if (!long_seen_q) begin
                err_long_d  = 1'b1;
                long_seen_d = 1'b1;
            end
            if (eop) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            blur_en_q    <= 1'b0;
            long_seen_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            use_blur_q   <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            blur_en_q    <= blur_en_d;
            long_seen_q  <= long_seen_d;
            out_valid_q  <= out_valid_d;
            use_blur_q   <= use_blur_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    // State resets to IDLE where sop alone would accept, so gate with reset explicitly.
    assign shift_en   = reset_n & accept;
    assign out_valid  = out_valid_q;
    assign use_blur   = use_blur_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign frame_done = frame_done_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;

endmodule
